// File: rtl/mem_pkg.sv
// Shared data-memory definitions: funct3 width codes and responder FSM states.
// Used by the control unit, the data memory and the data-memory responder.
package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for RISC-V byte/half/word accesses.
// Purely combinational: store byte enables and data, load extraction/extension, alignment error.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        i_write,
    input  logic [2:0]  i_ctrl,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[8*i_addr_lo +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_be    = '0;
        o_wdata = '0;
        o_rdata = '0;
        o_err   = 1'b0;
        case (i_ctrl)
            MEM_B, MEM_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_ctrl == MEM_B) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
                o_err   = i_write && (i_ctrl == MEM_BU);
            end
            MEM_H, MEM_HU: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = (i_ctrl == MEM_H) ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
                o_err   = i_addr_lo[0] || (i_write && (i_ctrl == MEM_HU));
            end
            MEM_W: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rword;
                o_err   = |i_addr_lo;
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
        // A rejected access must neither touch the array nor leak read data.
        if (o_err) begin
            o_be    = '0;
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, held response.
// Replaces the zero-latency data array when running against slower memory.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   WAIT  | request captured, counting down wait states
//   RESP  | committed; response held until rsp_ready
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    mem_state_e  r_state;
    mem_state_e  w_state_nxt;
    logic [CW-1:0] r_cnt;

    logic        r_write;
    logic [2:0]  r_ctrl;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_error;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_commit;
    logic        w_op_write;
    logic [2:0]  w_op_ctrl;
    logic [31:0] w_op_addr;
    logic [31:0] w_op_wdata;
    logic [AW-1:0] w_word_idx;
    logic [31:0] w_rword;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_rdata_ext;
    logic        w_align_err;
    logic        w_oor;
    logic        w_err;

    assign w_accept = req_valid && (r_state == IDLE);

    // With zero latency the commit edge is the acceptance edge, so the live inputs are used.
    assign w_op_write = (r_state == IDLE) ? req_write : r_write;
    assign w_op_ctrl  = (r_state == IDLE) ? req_ctrl  : r_ctrl;
    assign w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    assign w_word_idx = w_op_addr[AW+1:2];
    assign w_rword    = r_mem[w_word_idx];
    assign w_oor      = (w_op_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err      = w_align_err || w_oor;

    mem_lane_align u_align (
        .i_write   (w_op_write),
        .i_ctrl    (w_op_ctrl),
        .i_addr_lo (w_op_addr[1:0]),
        .i_wdata   (w_op_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wdata   (w_wdata_sh),
        .o_rdata   (w_rdata_ext),
        .o_err     (w_align_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_state_nxt = RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                    w_commit    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write <= 1'b0;
            r_ctrl  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_ctrl  <= req_ctrl;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_error <= 1'b0;
        end else if (w_commit) begin
            r_error <= w_err;
            r_rdata <= (w_err || w_op_write) ? 32'h0 : w_rdata_ext;
        end
    end

    // Array is deliberately outside reset; a reset also blocks any pending commit.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && w_op_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 instance and one LATENCY=0 instance.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [2:0]  a_req_ctrl;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_error;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [2:0]  b_req_ctrl;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_error;
    logic [31:0] b_rsp_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_write (a_req_write),
        .req_ctrl  (a_req_ctrl),
        .req_addr  (a_req_addr),
        .req_wdata (a_req_wdata),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (a_rsp_ready),
        .rsp_rdata (a_rsp_rdata),
        .rsp_error (a_rsp_error)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_write (b_req_write),
        .req_ctrl  (b_req_ctrl),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_rdata (b_rsp_rdata),
        .rsp_error (b_rsp_error)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on instance A; hold > 0 keeps rsp_ready low for hold extra cycles.
    task automatic txn_a(input logic w, input logic [2:0] c, input logic [31:0] ad,
                         input logic [31:0] d, input int hold, input logic [31:0] hold_exp,
                         output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_write = w;
        a_req_ctrl  = c;
        a_req_addr  = ad;
        a_req_wdata = d;
        a_rsp_ready = (hold == 0);
        n = 0;
        while (!a_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_req_ready) check_vec("accept_timeout", {31'b0, a_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        a_req_write = ~w;
        a_req_ctrl  = 3'b111;
        a_req_addr  = ~ad;
        a_req_wdata = ~d;
        lat = 0;
        @(negedge clk);
        while (!a_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = a_rsp_rdata;
        er = a_rsp_error;
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check_vec("hold_valid", {31'b0, a_rsp_valid}, 32'd1);
                check_vec("hold_rdata", a_rsp_rdata, hold_exp);
                check_vec("hold_req_ready", {31'b0, a_req_ready}, 32'd0);
            end
            a_rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        if (hold > 0) begin
            @(negedge clk);
            check_vec("req_ready_after", {31'b0, a_req_ready}, 32'd1);
        end
    endtask

    task automatic do_a(input string tag, input logic w, input logic [2:0] c,
                        input logic [31:0] ad, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn_a(w, c, ad, d, 0, 32'h0, rd, er, lat);
        check_vec({tag, "_rdata"}, rd, exp_rd);
        check_vec({tag, "_error"}, {31'b0, er}, {31'b0, exp_er});
        check_vec({tag, "_lat"}, 32'(lat), 32'd2);
    endtask

    task automatic check_reset_vals(input string tag);
        check_vec({tag, "_req_ready"}, {31'b0, a_req_ready}, 32'd1);
        check_vec({tag, "_rsp_valid"}, {31'b0, a_rsp_valid}, 32'd0);
        check_vec({tag, "_rsp_rdata"}, a_rsp_rdata, 32'd0);
        check_vec({tag, "_rsp_error"}, {31'b0, a_rsp_error}, 32'd0);
    endtask

    logic        b_w   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] b_ad  [4] = '{32'h40, 32'h40, 32'h44, 32'h44};
    logic [31:0] b_d   [4] = '{32'hA5A50001, 32'h0, 32'h0BADF00D, 32'h0};
    logic [31:0] b_exp [4] = '{32'h0, 32'hA5A50001, 32'h0, 32'h0BADF00D};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc_cyc [4];
        int          rsp_cyc [4];
        logic [31:0] rsp_d   [4];
        logic        rsp_e   [4];
        int          ia, ir;

        reset       = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_ctrl = 3'b0;
        a_req_addr  = '0;   a_req_wdata = '0;   a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_ctrl = 3'b0;
        b_req_addr  = '0;   b_req_wdata = '0;   b_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        do_a("sw10", 1'b1, MEM_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_a("lw10", 1'b0, MEM_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        do_a("sw20",  1'b1, MEM_W,  32'h20, 32'h00000000, 32'h0, 1'b0);
        do_a("sb21",  1'b1, MEM_B,  32'h21, 32'h12345680, 32'h0, 1'b0);
        do_a("sh22",  1'b1, MEM_H,  32'h22, 32'hABCDF00F, 32'h0, 1'b0);
        do_a("lw20",  1'b0, MEM_W,  32'h20, 32'h0, 32'hF00F8000, 1'b0);
        do_a("lb21",  1'b0, MEM_B,  32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
        do_a("lbu21", 1'b0, MEM_BU, 32'h21, 32'h0, 32'h00000080, 1'b0);
        do_a("lhu22", 1'b0, MEM_HU, 32'h22, 32'h0, 32'h0000F00F, 1'b0);
        do_a("lh22",  1'b0, MEM_H,  32'h22, 32'h0, 32'hFFFFF00F, 1'b0);
        do_a("lh20",  1'b0, MEM_H,  32'h20, 32'h0, 32'hFFFF8000, 1'b0);

        do_a("sw00",    1'b1, MEM_W,  32'h00,   32'h11111111, 32'h0, 1'b0);
        do_a("lw12",    1'b0, MEM_W,  32'h12,   32'h0,        32'h0, 1'b1);
        do_a("sh13",    1'b1, MEM_H,  32'h13,   32'h0000FFFF, 32'h0, 1'b1);
        do_a("sw_oor",  1'b1, MEM_W,  32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_a("l011",    1'b0, 3'b011, 32'h10,   32'h0,        32'h0, 1'b1);
        do_a("sbu10",   1'b1, MEM_BU, 32'h10,   32'h000000FF, 32'h0, 1'b1);
        do_a("lw10_2",  1'b0, MEM_W,  32'h10,   32'h0, 32'hDEADBEEF, 1'b0);
        do_a("lw00",    1'b0, MEM_W,  32'h00,   32'h0, 32'h11111111, 1'b0);

        txn_a(1'b0, MEM_W, 32'h10, 32'h0, 5, 32'hDEADBEEF, rd, er, lat);
        check_vec("bp_rdata", rd, 32'hDEADBEEF);
        check_vec("bp_error", {31'b0, er}, 32'd0);

        do_a("sw30", 1'b1, MEM_W, 32'h30, 32'hCAFE0030, 32'h0, 1'b0);
        do_a("lw30", 1'b0, MEM_W, 32'h30, 32'h0, 32'hCAFE0030, 1'b0);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_ctrl = MEM_W;
        a_req_addr  = 32'h30; a_req_wdata = 32'h12345678;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_wait");
        do_a("lw30_after", 1'b0, MEM_W, 32'h30, 32'h0, 32'hCAFE0030, 1'b0);

        // Zero-latency instance, request held valid, rsp_ready tied high.
        ia = 0;
        ir = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (b_rsp_valid && ir < 4) begin
                rsp_cyc[ir] = k;
                rsp_d[ir]   = b_rsp_rdata;
                rsp_e[ir]   = b_rsp_error;
                ir++;
            end
            if (b_req_ready) begin
                if (ia < 4) begin
                    b_req_valid = 1'b1;
                    b_req_write = b_w[ia];
                    b_req_ctrl  = MEM_W;
                    b_req_addr  = b_ad[ia];
                    b_req_wdata = b_d[ia];
                    acc_cyc[ia] = k;
                    ia++;
                end else begin
                    b_req_valid = 1'b0;
                end
            end
        end
        check_vec("z_accepts", 32'(ia), 32'd4);
        check_vec("z_responses", 32'(ir), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ia && i < ir) begin
                check_vec($sformatf("z_lat%0d", i), 32'(rsp_cyc[i] - acc_cyc[i]), 32'd1);
                check_vec($sformatf("z_rdata%0d", i), rsp_d[i], b_exp[i]);
                check_vec($sformatf("z_error%0d", i), {31'b0, rsp_e[i]}, 32'd0);
            end
            if (i > 0 && i < ia) begin
                check_vec($sformatf("z_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and applies a configurable number of wait states. It performs RISC-V byte, halfword and word access with little-endian lane steering and load sign or zero extension. Each request ends with a response that is held until the core accepts it. It replaces the zero-latency data array when the core runs against slower or shared memory.

## Interface

**Parameters**
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the backing array. Must be a power of two.
- `LATENCY`, default 2: wait-state cycles between acceptance and commit. Must be ≥ 0.

**Ports**
- `clk` in 1: single clock. Everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_ctrl` in 3: funct3 width code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core accepts the response.
- `rsp_rdata` out 32: load result after extension. It is 0 for stores and on errors.
- `rsp_error` out 1: the access was rejected.

## Operation

**FSM states**
- IDLE: `req_ready` = 1.
  - Acceptance happens when `req_valid` and `req_ready` are both 1 at an edge.
  - At acceptance, capture write, ctrl, addr and wdata. The request inputs are don't-care afterwards.
  - Next state is WAIT when `LATENCY` > 0, otherwise RESP.
- WAIT: a down-counter is loaded with `LATENCY` − 1 at acceptance. When it reaches 0, the next state is RESP.
- RESP:
  - `rsp_valid` = 1, with `rsp_rdata` and `rsp_error` stable.
  - When `rsp_ready` = 1 at an edge, return to IDLE.
  - `req_ready` = 0 in this state, so there is no overlap between requests.

**Commit and error checks**
- Commit happens at the edge that enters RESP. At that edge the store is written, or the load is read and registered.
- An error is flagged when any of the following holds:
  - ctrl is 011, 110 or 111;
  - a store uses ctrl 100 or 101;
  - a halfword access has `addr[0]` = 1;
  - a word access has `addr[1:0]` ≠ 0;
  - `addr[31:2]` ≥ `DEPTH_WORDS`.
- On error: no array write, `rsp_rdata` = 0, `rsp_error` = 1.

**Lane rules (little-endian, word index = `addr[31:2]`)**
- SB writes `wdata[7:0]` into byte lane `addr[1:0]`.
- SH writes `wdata[15:0]` into lanes {2·`addr[1]`, 2·`addr[1]`+1}.
- SW writes all four lanes.
- Unaddressed lanes are unchanged.
- LB and LH sign-extend from bit 7 or bit 15 of the selected lane(s). LBU and LHU zero-extend.

**Reset**
- Reset returns the FSM to IDLE, clears the counter, and clears the captured request and registered response.
- The array contents are not affected by reset.
- Reset asserted in WAIT means the pending store never commits.
- Reset asserted in RESP drops the response.

## Timing

**Reset values**
- `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0.

**Latency**
- Acceptance is at edge E0. `rsp_valid` rises in the cycle after edge E0 + `LATENCY`.
- With `LATENCY` = 0, `rsp_valid` is high in the cycle immediately after acceptance.

**Throughput**
- Best case is one transaction per `LATENCY` + 2 cycles, which occurs when `rsp_ready` is already high.

**Response holding**
- `rsp_*` holds unchanged for every cycle that `rsp_ready` is 0.

**Read/write ordering**
- A load following a store to the same word returns the stored data, because commits are strictly ordered.

**Output drive**
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` or `rsp_ready` to any output.

## Structure

**Package `mem_pkg`**
- funct3 width constants: `MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`.
- FSM state enum: IDLE, WAIT, RESP.
- Shared by the control unit, the existing data memory and this block.

**Sub-module `mem_lane_align`**
- Combinational.
- Store side: produces the byte-enable mask and shifted write data from ctrl and `addr[1:0]`.
- Load side: extracts and extends the selected lane(s).
- Also produces the misalignment/illegal-ctrl error bit.
- Reused by the existing data memory.

**Top-level contents**
- The FSM, the wait counter, the capture registers, the response registers, and the `reg [31:0]` array.

## Test plan

All scenarios use `LATENCY` = 2 unless stated otherwise.

1. **Word store then word load.** SW 0xDEADBEEF to addr 0x10, then LW from 0x10.
   - `rsp_rdata` = 0xDEADBEEF, `rsp_error` = 0.
   - `rsp_valid` is seen exactly 3 cycles after each acceptance edge.
2. **Byte stores and extension.** After SW 0x00000000 to 0x20, SB 0x80 to 0x21 and SH 0xF00F to 0x22.
   - LW 0x20 returns 0xF00F8000.
   - LB 0x21 returns 0xFFFFFF80.
   - LBU 0x21 returns 0x00000080.
   - LHU 0x22 returns 0x0000F00F.
3. **Error cases.** Each case returns `rsp_error` = 1 and `rsp_rdata` = 0, and a subsequent LW 0x10 still reads 0xDEADBEEF.
   - LW at 0x12.
   - SH at 0x13.
   - SW at address 4·`DEPTH_WORDS`.
   - Load with ctrl 011.
4. **Response backpressure.** Hold `rsp_ready` = 0 for 5 cycles during a response.
   - `rsp_valid` and `rsp_rdata` stay stable.
   - `req_ready` = 0 throughout.
   - One cycle after `rsp_ready` rises, `req_ready` = 1.
5. **Reset during WAIT.** Accept SW 0x12345678 to 0x30, assert `reset` in the first WAIT cycle, then LW 0x30.
   - The load returns the value stored there before the reset, not 0x12345678.
   - Outputs equal their reset values in the cycle after reset.
6. **Zero latency.** With `LATENCY` = 0, run back-to-back SW/LW with `rsp_ready` tied high.
   - Each response appears one cycle after acceptance.
   - A new acceptance happens every 2 cycles.
